// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scan sequencer.
package hub75_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StShiftGo   = 3'd1,
    StShiftWait = 3'd2,
    StBlankWait = 3'd3,
    StLatch     = 3'd4,
    StFire      = 3'd5,
    StNext      = 3'd6,
    StFrameWait = 3'd7
  } scan_state_e;

  localparam int unsigned MaxPlanes = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned row_addr_width(input int unsigned n_rows);
    return idx_width(n_rows);
  endfunction

  function automatic logic [MaxPlanes-1:0] plane_onehot(input int unsigned p);
    return MaxPlanes'(1) << p;
  endfunction

endpackage

// File: rtl/hub75_bcm_scan.sv
// Row / bit-plane sequencer feeding the HUB75 line shifter and blanking stage.
// Optional macro HUB75_BCM_SCAN_FRAME_SYNC_EN adds a frame_swap_ack hold at frame end.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int unsigned N_ROWS     = 32,
  parameter int unsigned LOG_N_ROWS = 5,
  parameter int unsigned N_PLANES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef HUB75_BCM_SCAN_FRAME_SYNC_EN
  input  logic                  frame_swap_ack,
`endif
  input  logic                  ctrl_run,
  output logic                  frame_end,
  output logic                  shift_go,
  output logic [LOG_N_ROWS-1:0] shift_row,
  output logic [N_PLANES-1:0]   shift_plane,
  input  logic                  shift_rdy,
  output logic [LOG_N_ROWS-1:0] hub75_addr,
  output logic                  hub75_le,
  output logic                  blank_go,
  output logic [N_PLANES-1:0]   blank_plane,
  input  logic                  blank_rdy
);

  localparam int unsigned PlaneW = idx_width(N_PLANES);
  localparam logic [PlaneW-1:0]     LastPlane = PlaneW'(N_PLANES - 1);
  localparam logic [LOG_N_ROWS-1:0] LastRow   = LOG_N_ROWS'(N_ROWS - 1);

  scan_state_e state_q, state_d;
  logic [LOG_N_ROWS-1:0] row_q, row_d;
  logic [PlaneW-1:0]     plane_q, plane_d;

  logic                  frame_end_q, frame_end_d;
  logic                  shift_go_q, shift_go_d;
  logic [LOG_N_ROWS-1:0] shift_row_q, shift_row_d;
  logic [N_PLANES-1:0]   shift_plane_q, shift_plane_d;
  logic [LOG_N_ROWS-1:0] hub75_addr_q, hub75_addr_d;
  logic                  hub75_le_q, hub75_le_d;
  logic                  blank_go_q, blank_go_d;
  logic [N_PLANES-1:0]   blank_plane_q, blank_plane_d;

  logic                  frame_last;
  logic [N_PLANES-1:0]   plane_oh;

  assign frame_last = (row_q == LastRow) && (plane_q == LastPlane);
  assign plane_oh   = N_PLANES'(plane_onehot(32'(plane_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      plane_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_run) begin
          state_d = StShiftGo;
          row_d   = '0;
          plane_d = '0;
        end
      end
      StShiftGo: begin
        if (shift_rdy) state_d = StShiftWait;
      end
      // shift_go_q is high only in the first wait cycle, before the shifter drops rdy.
      StShiftWait: begin
        if (!shift_go_q && shift_rdy) state_d = StBlankWait;
      end
      StBlankWait: begin
        if (blank_rdy) state_d = StLatch;
      end
      StLatch: state_d = StFire;
      StFire:  state_d = StNext;
      StNext: begin
        if (plane_q == LastPlane) begin
          plane_d = '0;
          row_d   = (row_q == LastRow) ? '0 : row_q + 1'b1;
        end else begin
          plane_d = plane_q + 1'b1;
        end
        if (!frame_last) begin
          state_d = StShiftGo;
        end else begin
`ifdef HUB75_BCM_SCAN_FRAME_SYNC_EN
          state_d = StFrameWait;
`else
          state_d = ctrl_run ? StShiftGo : StIdle;
`endif
        end
      end
`ifdef HUB75_BCM_SCAN_FRAME_SYNC_EN
      StFrameWait: begin
        if (frame_swap_ack) state_d = ctrl_run ? StShiftGo : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_go_d    = (state_q == StShiftGo) && shift_rdy;
    shift_row_d   = shift_go_d ? row_q : shift_row_q;
    shift_plane_d = shift_go_d ? plane_oh : shift_plane_q;
    hub75_le_d    = (state_q == StLatch);
    hub75_addr_d  = hub75_le_d ? row_q : hub75_addr_q;
    blank_go_d    = (state_q == StFire);
    blank_plane_d = blank_go_d ? plane_oh : '0;
    frame_end_d   = (state_q == StNext) && frame_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_end_q   <= 1'b0;
      shift_go_q    <= 1'b0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      hub75_addr_q  <= '0;
      hub75_le_q    <= 1'b0;
      blank_go_q    <= 1'b0;
      blank_plane_q <= '0;
    end else begin
      frame_end_q   <= frame_end_d;
      shift_go_q    <= shift_go_d;
      shift_row_q   <= shift_row_d;
      shift_plane_q <= shift_plane_d;
      hub75_addr_q  <= hub75_addr_d;
      hub75_le_q    <= hub75_le_d;
      blank_go_q    <= blank_go_d;
      blank_plane_q <= blank_plane_d;
    end
  end

  assign frame_end   = frame_end_q;
  assign shift_go    = shift_go_q;
  assign shift_row   = shift_row_q;
  assign shift_plane = shift_plane_q;
  assign hub75_addr  = hub75_addr_q;
  assign hub75_le    = hub75_le_q;
  assign blank_go    = blank_go_q;
  assign blank_plane = blank_plane_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Self-checking bench for hub75_bcm_scan with shifter and blanking-stage models.
module tb_hub75_bcm_scan;

  localparam int NRows   = 4;
  localparam int LogRows = 2;
  localparam int NPlanes = 3;
  localparam int NPairs  = NRows * NPlanes;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ctrl_run = 1'b0;
  logic               frame_end, shift_go, shift_rdy, hub75_le, blank_go, blank_rdy;
  logic [LogRows-1:0] shift_row, hub75_addr;
  logic [NPlanes-1:0] shift_plane, blank_plane;
`ifdef HUB75_BCM_SCAN_FRAME_SYNC_EN
  logic               frame_swap_ack = 1'b1;
`endif

  hub75_bcm_scan #(
    .N_ROWS    (NRows),
    .LOG_N_ROWS(LogRows),
    .N_PLANES  (NPlanes)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef HUB75_BCM_SCAN_FRAME_SYNC_EN
    .frame_swap_ack(frame_swap_ack),
`endif
    .ctrl_run      (ctrl_run),
    .frame_end     (frame_end),
    .shift_go      (shift_go),
    .shift_row     (shift_row),
    .shift_plane   (shift_plane),
    .shift_rdy     (shift_rdy),
    .hub75_addr    (hub75_addr),
    .hub75_le      (hub75_le),
    .blank_go      (blank_go),
    .blank_plane   (blank_plane),
    .blank_rdy     (blank_rdy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference ordering: pair n of the scan is row (n / NPlanes) mod NRows, plane n mod NPlanes.
  function automatic int exp_row(input int n);
    return (n / NPlanes) % NRows;
  endfunction

  function automatic int exp_plane(input int n);
    return 1 << (n % NPlanes);
  endfunction

  function automatic int blank_len(input logic [NPlanes-1:0] oh, input int unit);
    int len;
    len = unit;
    for (int i = 0; i < NPlanes; i++) if (oh[i]) len = unit << i;
    return len;
  endfunction

  // Shifter and blanking-stage models
  int shift_len  = 10;
  int blank_unit = 4;
  int rnd        = 0;
  int sh_cnt, bl_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_cnt <= 0;
      bl_cnt <= 0;
    end else begin
      if (shift_go) sh_cnt <= (rnd != 0) ? int'($urandom_range(1, 20)) : shift_len;
      else if (sh_cnt != 0) sh_cnt <= sh_cnt - 1;
      if (blank_go) bl_cnt <= (rnd != 0) ? int'($urandom_range(1, 40))
                                         : blank_len(blank_plane, blank_unit);
      else if (bl_cnt != 0) bl_cnt <= bl_cnt - 1;
    end
  end

  assign shift_rdy = (sh_cnt == 0);
  assign blank_rdy = (bl_cnt == 0);

  // Continuous monitor against the reference ordering and handshake rules
  int shift_n, fire_n, fe_n;
  logic hold, moved, le_prev, bg_prev;
  logic [LogRows-1:0] hold_row, addr_prev;
  logic [NPlanes-1:0] hold_plane;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        shift_n = 0; fire_n = 0; fe_n = 0;
        hold = 0; moved = 0; le_prev = 0; bg_prev = 0; addr_prev = '0;
      end else begin
        if (shift_go) begin
          check("shift_row", int'(shift_row), exp_row(shift_n));
          check("shift_plane", int'(shift_plane), exp_plane(shift_n));
          shift_n++;
          hold = 1; moved = 0; hold_row = shift_row; hold_plane = shift_plane;
        end else if (hold) begin
          if (shift_row != hold_row || shift_plane != hold_plane) moved = 1;
          if (shift_rdy) begin
            check("shift_hold", int'(moved), 0);
            hold = 0;
          end
        end
        if (blank_go) begin
          check("blank_plane", int'(blank_plane), exp_plane(fire_n));
          check("fire_addr", int'(hub75_addr), exp_row(fire_n));
          check("le_before_go", int'(le_prev), 1);
          fire_n++;
        end
        if (hub75_le) check("le_blank_rdy", int'(blank_rdy), 1);
        if (hub75_addr != addr_prev) check("addr_on_le", int'(hub75_le), 1);
        if (frame_end) begin
          fe_n++;
          check("frame_end_after_fire", int'(bg_prev), 1);
          check("frame_end_pair", fire_n % NPairs, 0);
        end
        le_prev = hub75_le; bg_prev = blank_go; addr_prev = hub75_addr;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ctrl_run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int quiet, cyc;
    quiet = 0; cyc = 0;
    while (quiet < 300 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (shift_go || blank_go || frame_end) quiet = 0;
      else quiet++;
    end
    check({name, "_settled"}, int'(quiet >= 300), 1);
  endtask

  task automatic run_scenario(input int sl, input int bu, input int r, input int d,
                              input int ef, input int efe, input string name);
    int local_n, cyc;
    logic dropped;
    shift_len = sl; blank_unit = bu; rnd = r;
    do_reset();
    local_n = 0; cyc = 0; dropped = 0;
    while (!dropped && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (blank_go) begin
        if (local_n == d) begin
          ctrl_run = 1'b0;
          dropped = 1;
        end
        local_n++;
      end
    end
    check({name, "_drop_reached"}, int'(dropped), 1);
    wait_quiet(name);
    check({name, "_fires"}, fire_n, ef);
    check({name, "_shift_gos"}, shift_n, ef);
    check({name, "_frame_ends"}, fe_n, efe);
  endtask

  typedef struct {
    int sl;
    int bu;
    int drop_at;
    int exp_fires;
    int exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d, cyc;
    logic found;

    vecs[0] = '{10, 4, 4, 12, 1};   // drop at row 1 plane 1
    vecs[1] = '{2, 1, 15, 24, 2};
    vecs[2] = '{12, 2, 11, 12, 1};  // drop on the last pair of a frame
    vecs[3] = '{3, 8, 30, 36, 3};
    vecs[4] = '{10, 4, 12, 24, 2};  // drop on the first pair of frame 2

    #1;
    check("reset_outputs",
          int'({frame_end, shift_go, shift_row, shift_plane, hub75_addr, hub75_le, blank_go,
                blank_plane}), 0);

    for (int i = 0; i < 5; i++)
      run_scenario(vecs[i].sl, vecs[i].bu, 0, vecs[i].drop_at, vecs[i].exp_fires,
                   vecs[i].exp_fe, $sformatf("vec%0d", i));

    for (int i = 0; i < 3; i++) begin
      d = int'($urandom_range(0, 3 * NPairs - 1));
      run_scenario(0, 1, 1, d, (d / NPairs + 1) * NPairs, d / NPairs + 1,
                   $sformatf("rand%0d", i));
    end

    // Overlap: next shift_go two cycles after the plane-2 fire, while blanking still runs
    shift_len = 10; blank_unit = 4; rnd = 0;
    do_reset();
    found = 0; cyc = 0;
    while (!found && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (blank_go && blank_plane == 3'b100) found = 1;
    end
    check("overlap_fire_seen", int'(found), 1);
    @(negedge clk);
    check("overlap_no_early_go", int'(shift_go), 0);
    @(negedge clk);
    check("overlap_shift_go", int'(shift_go), 1);
    check("overlap_blank_busy", int'(blank_rdy), 0);
    ctrl_run = 1'b0;
    wait_quiet("overlap");

    // Asynchronous reset while waiting on the shifter
    do_reset();
    found = 0; cyc = 0;
    while (!found && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (shift_go && shift_row == 2'd1) found = 1;
    end
    check("rst_row1_shift_seen", int'(found), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_reset_outputs",
          int'({frame_end, shift_go, shift_row, shift_plane, hub75_addr, hub75_le, blank_go,
                blank_plane}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ctrl_run = 1'b1;
    found = 0; cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (shift_go) found = 1;
    end
    check("post_rst_shift_go", int'(found), 1);
    check("post_rst_row", int'(shift_row), 0);
    check("post_rst_plane", int'(shift_plane), 1);
    ctrl_run = 1'b0;
    wait_quiet("post_rst");

`ifdef HUB75_BCM_SCAN_FRAME_SYNC_EN
    // Frame sync: hold at frame end until the swap ack arrives
    frame_swap_ack = 1'b0;
    do_reset();
    found = 0; cyc = 0;
    while (!found && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (frame_end) found = 1;
    end
    check("sync_frame_end_seen", int'(found), 1);
    d = 0;
    repeat (20) begin
      @(negedge clk);
      if (shift_go) d++;
    end
    check("sync_held_no_shift", d, 0);
    frame_swap_ack = 1'b1;
    found = 0; cyc = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (shift_go) found = 1;
    end
    check("sync_shift_after_ack", int'(found), 1);
    check("sync_ack_latency", cyc, 2);
    ctrl_run = 1'b0;
    wait_quiet("sync");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_scan.md
Name: hub75_bcm_scan

Overview:
- Upstream sequencer for the HUB75 blanking stage.
- Walks every row and every BCM bit-plane of a frame:
  - commands the line shifter to load plane data;
  - latches the shifted data and drives the row address;
  - then fires the blanking stage with a one-hot plane weight.
- The shift of the next plane overlaps display of the current one.
- Sits between the frame buffer/shifter and the blanking stage.

Parameters:
- N_ROWS, 32, number of multiplexed rows per frame; power of two.
- LOG_N_ROWS, 5, log2(N_ROWS); width of the row address.
- N_PLANES, 8, BCM bit-planes per row; plane p weight = 2^p.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- ctrl_run  in  1  level; enable scanning, sampled at frame boundaries only.
- frame_end  out  1  one-cycle pulse after the last plane of the last row is fired.
- shift_go  out  1  one-cycle pulse: shifter loads (shift_row, shift_plane).
- shift_row  out  LOG_N_ROWS  row to shift; held stable from shift_go until shift_rdy returns.
- shift_plane  out  N_PLANES  one-hot plane to shift; same stability rule as shift_row.
- shift_rdy  in  1  shifter idle; drops the cycle after shift_go and rises when the line is complete.
- hub75_addr  out  LOG_N_ROWS  panel row address, registered.
- hub75_le  out  1  panel latch strobe, registered, one cycle.
- blank_go  out  1  one-cycle pulse to the blanking stage.
- blank_plane  out  N_PLANES  one-hot display length, valid with blank_go.
- blank_rdy  in  1  blanking stage idle (panel blanked).

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; row counter 0; plane counter 0.
  - Reset mid-frame aborts immediately; no pending go is replayed.
- States: IDLE, SHIFT_GO, SHIFT_WAIT, BLANK_WAIT, LATCH, FIRE, NEXT.
- IDLE: if ctrl_run=1, go to SHIFT_GO with row=0, plane=0.
- SHIFT_GO: when shift_rdy=1, pulse shift_go for one cycle and go to SHIFT_WAIT.
- SHIFT_WAIT:
  - shift_rdy is ignored in the first cycle (the shifter's drop latency).
  - Afterwards, wait for shift_rdy=1, then go to BLANK_WAIT.
- BLANK_WAIT:
  - Wait for blank_rdy=1, i.e. the previous plane's display period has finished and the panel is blank.
  - If already high, proceed next cycle.
- LATCH:
  - hub75_le=1 and hub75_addr=current row, on the same registered edge.
  - The address only changes while the panel is blanked.
- FIRE:
  - blank_go=1 with blank_plane = 1<<plane.
  - Fire is only reachable with blank_rdy=1, so no go is ever dropped.
- NEXT:
  - If plane < N_PLANES-1: plane+1.
  - Otherwise plane=0 and row+1. On the row wrap N_ROWS-1→0, pulse frame_end.
  - Then:
    - mid-frame: go to SHIFT_GO;
    - at frame end with ctrl_run=1: go to SHIFT_GO;
    - at frame end with ctrl_run=0: go to IDLE.
- Pipelining: the next shift proceeds while blanking counts down. Steady-state throughput is bounded by max(shift time, display time) + 3 cycles.
- ctrl_run deasserted mid-frame: the current frame completes, then the block stops.
- Counters wrap modulo N_ROWS and N_PLANES exactly; no skipped or repeated (row, plane) pairs.

Optional Feature:
- Macro: HUB75_BCM_SCAN_FRAME_SYNC_EN.
- When defined:
  - adds input frame_swap_ack (1 bit);
  - at frame end, after the frame_end pulse, the FSM holds in a FRAME_WAIT state until frame_swap_ack=1, then applies the ctrl_run decision;
  - the ack is sampled only in FRAME_WAIT.
- When undefined: the port is absent and NEXT transitions directly as above.

Decomposition:
- Shared package hub75_pkg holds:
  - FSM state encoding localparams;
  - the one-hot plane helper function (plane index → 1<<p);
  - the HUB75 row-address width helper.
- No sub-module: both counters and the FSM fit inline in one block.

Test Plan:
- Common bench setup:
  - N_ROWS=4, N_PLANES=3, ctrl_run=1;
  - shifter model: rdy low 10 cycles after go;
  - blank model: rdy low 4·2^p cycles after go.
- Full frame: observe 12 blank_go with blank_plane 001,010,100 repeating; hub75_addr 0,0,0,1,…,3; frame_end exactly once, the cycle after the 12th fire's NEXT.
- Ordering: for every pair, hub75_le precedes blank_go by 1 cycle, hub75_le occurs only with blank_rdy=1, and hub75_addr changes only on hub75_le cycles.
- Overlap: with blank plane 2 lasting 16 cycles, shift_go for the next pair occurs 2 cycles after blank_go (before blank_rdy rises).
- ctrl_run dropped at row 1 plane 1: the frame finishes through row 3 plane 2, frame_end pulses, the block returns to IDLE and no further shift_go occurs.
- Async reset asserted in SHIFT_WAIT: all outputs are 0 without a clock edge; after release with ctrl_run=1, the first shift_go carries row 0 and plane 001.
- With HUB75_BCM_SCAN_FRAME_SYNC_EN and frame_swap_ack held low 20 cycles: no shift_go for 20 cycles after frame_end, and the first shift_go follows the ack.
